strait_selftest_ctrl: RTL and testbench
=======================================

Name: strait_selftest_ctrl

Overview:
Sequences one self-test run of the systolic array's partial-sum checker. For each test pattern it launches the pattern into the array and presents the golden sum to the column comparator bank. It waits for the array latency, then samples the comparator's registered per-column mismatch flags. Mismatches are accumulated into a sticky per-column fault map, which the recovery logic consumes to remap faulty columns.

Parameters:
SYSTOLIC_SIZE, 8, number of array columns and comparator mismatch flags
PS_WIDTH, 24, partial-sum / golden-answer width
NUM_PATTERNS, 16, test patterns per run (>=1)
ARRAY_LATENCY, 16, cycles from launch pulse to column partial sums valid at comparator input (>=1)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
start  input  1  begin a run; honoured only in IDLE or DONE
abort  input  1  terminate current run, return to IDLE
golden_answer  input  PS_WIDTH  golden sum for pat_addr, combinational from golden ROM, valid same cycle
mismatch  input  SYSTOLIC_SIZE  comparator outputs (registered inside comparator, 1-cycle latency)
pat_addr  output  clog2(NUM_PATTERNS) (min 1)  current pattern index to pattern/golden ROMs
launch  output  1  one-cycle pulse: inject pattern pat_addr into array
correct_answer  output  PS_WIDTH  golden sum driven to comparator bank
fault_map  output  SYSTOLIC_SIZE  sticky per-column fault flags
busy  output  1  run in progress
done  output  1  run completed; level, held until next start or abort
fail  output  1  done & |fault_map

Behaviour:
- Reset: state IDLE; pat_addr, launch, correct_answer, fault_map, busy, done, fail, and wait counter all 0.
- States: IDLE, LAUNCH, WAIT, CAPTURE, DONE.
- IDLE/DONE with start=1: clear fault_map, done, fail; pat_addr<=0; go to LAUNCH. start in any other state is ignored.
- LAUNCH, 1 cycle:
  - launch=1, busy=1.
  - At the cycle's end, correct_answer<=golden_answer; it holds until the next LAUNCH.
  - wait counter<=0; go to WAIT.
- WAIT, exactly ARRAY_LATENCY cycles: counter increments 0..ARRAY_LATENCY-1, then go to CAPTURE.
- Timing: with the launch cycle t0, partial sums are valid at t0+ARRAY_LATENCY; the comparator registers the result and mismatch is valid in cycle t0+ARRAY_LATENCY+1 (the CAPTURE cycle).
- CAPTURE, 1 cycle:
  - fault_map<=fault_map|mismatch.
  - If pat_addr==NUM_PATTERNS-1, go to DONE; otherwise pat_addr+1 and go to LAUNCH.
  - Per-pattern period is ARRAY_LATENCY+2 cycles.
- DONE: busy=0, done=1, fail=|fault_map; fault_map and pat_addr held.
- abort (any non-IDLE state, highest priority over start and state transitions):
  - Next state IDLE; busy=0, done=0, launch=0.
  - fault_map is retained; it is not cleared until the next start.
  - abort in IDLE has no effect.
- mismatch is ignored in every state except CAPTURE.
- fault_map bits never clear during a run.
- NUM_PATTERNS=1: a single LAUNCH/WAIT/CAPTURE sequence, then DONE.
- Reset asserted mid-run: immediate return to reset values; no partial results are kept.

Test Plan:
- Default params, start pulse, mismatch=0 always -> launch pulses at cycles 1,19,37,...,271 after start; done=1 and fail=0 at cycle 289; fault_map=0x00.
- mismatch=0x04 only in the CAPTURE of pattern 3, and 0x80 asserted in a WAIT cycle of pattern 5 -> fault_map=0x04 (the WAIT-cycle flag is ignored); fail=1 at done.
- golden_answer=addr*0x111111 -> correct_answer equals 0x333333 from the cycle after pattern 3's launch through its CAPTURE cycle.
- abort in the WAIT of pattern 7 after a fault 0x02 at pattern 2 -> IDLE next cycle, busy=0, done=0, fault_map=0x02; a later start clears fault_map and restarts at pat_addr=0.
- start pulsed while busy -> ignored; pattern sequence and cycle counts unchanged.
- NUM_PATTERNS=1, ARRAY_LATENCY=1, mismatch=0xFF -> launch, WAIT 1 cycle, CAPTURE; done at cycle 4 with fault_map=0xFF and fail=1; async reset mid-WAIT clears all outputs immediately.

Source files
------------

// File: rtl/strait_selftest_ctrl.sv
// strait_selftest_ctrl: sequences one self-test run of the systolic array's
// partial-sum checker. Each pattern is launched, the array latency is waited
// out, and the comparator's registered per-column mismatch flags are folded
// into a sticky fault map consumed by the column-remap recovery logic.
//
// Control protocol: start is a level sampled on the clock edge and honoured
// only in IDLE or DONE; abort is a level sampled on the clock edge, honoured
// in any non-IDLE state, and takes priority over start and over every state
// transition. launch is a single-cycle strobe with no back-pressure.
module strait_selftest_ctrl #(
  parameter  int SYSTOLIC_SIZE = 8,
  parameter  int PS_WIDTH      = 24,
  parameter  int NUM_PATTERNS  = 16,
  parameter  int ARRAY_LATENCY = 16,
  localparam int PA_W  = (NUM_PATTERNS  > 1) ? $clog2(NUM_PATTERNS)  : 1,
  localparam int CNT_W = (ARRAY_LATENCY > 1) ? $clog2(ARRAY_LATENCY) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic [PS_WIDTH-1:0]      golden_answer,
  input  logic [SYSTOLIC_SIZE-1:0] mismatch,
  output logic [PA_W-1:0]          pat_addr,
  output logic                     launch,
  output logic [PS_WIDTH-1:0]      correct_answer,
  output logic [SYSTOLIC_SIZE-1:0] fault_map,
  output logic                     busy,
  output logic                     done,
  output logic                     fail
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LAUNCH  = 3'd1,
    WAIT    = 3'd2,
    CAPTURE = 3'd3,
    DONE    = 3'd4
  } state_t;

  // state is kept as a named enum so assertion/checker binds can observe it
  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] wait_cnt;
  logic             abort_hit;
  logic             start_hit;
  logic             last_wait;
  logic             last_pat;

  assign abort_hit = abort && (state != IDLE);
  assign start_hit = start && ((state == IDLE) || (state == DONE)) && !abort_hit;
  assign last_wait = (wait_cnt == CNT_W'(ARRAY_LATENCY - 1));
  assign last_pat  = (pat_addr == PA_W'(NUM_PATTERNS - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic; abort overrides every other transition
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_hit) state_next = LAUNCH;
      LAUNCH:  state_next = WAIT;
      WAIT:    if (last_wait) state_next = CAPTURE;
      CAPTURE: state_next = last_pat ? DONE : LAUNCH;
      DONE:    if (start_hit) state_next = LAUNCH;
      default: state_next = IDLE;
    endcase
    if (abort_hit) state_next = IDLE;
  end

  // Datapath: pattern index, wait counter, golden latch and sticky fault map
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_addr       <= '0;
      wait_cnt       <= '0;
      correct_answer <= '0;
      fault_map      <= '0;
    end else if (!abort_hit) begin
      if (start_hit) begin
        pat_addr  <= '0;
        fault_map <= '0;
      end
      case (state)
        LAUNCH: begin
          correct_answer <= golden_answer;
          wait_cnt       <= '0;
        end
        WAIT: begin
          if (!last_wait) wait_cnt <= wait_cnt + 1'b1;
        end
        CAPTURE: begin
          // mismatch is registered in the comparator, so this cycle carries
          // the result for the partial sums that were valid one cycle earlier
          fault_map <= fault_map | mismatch;
          if (!last_pat) pat_addr <= pat_addr + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Moore outputs decoded from the current state
  always_comb begin
    launch = (state == LAUNCH);
    busy   = (state == LAUNCH) || (state == WAIT) || (state == CAPTURE);
    done   = (state == DONE);
    fail   = done && (|fault_map);
  end

endmodule

// File: tb/tb_strait_selftest_ctrl.sv
// Directed testbench for strait_selftest_ctrl: a default-parameter instance
// plus a NUM_PATTERNS=1 / ARRAY_LATENCY=1 instance sharing clock and reset.
module tb_strait_selftest_ctrl;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- default instance ----------------
  logic        start, abort;
  logic [23:0] golden_answer;
  logic [7:0]  mismatch;
  logic [3:0]  pat_addr;
  logic        launch, busy, done, fail;
  logic [23:0] correct_answer;
  logic [7:0]  fault_map;

  assign golden_answer = 24'(pat_addr) * 24'h111111;

  strait_selftest_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .golden_answer(golden_answer), .mismatch(mismatch),
    .pat_addr(pat_addr), .launch(launch), .correct_answer(correct_answer),
    .fault_map(fault_map), .busy(busy), .done(done), .fail(fail)
  );

  // ---------------- single-pattern, latency-1 instance ----------------
  logic        start1, abort1;
  logic [23:0] golden1;
  logic [7:0]  mismatch1;
  logic [0:0]  pat_addr1;
  logic        launch1, busy1, done1, fail1;
  logic [23:0] correct_answer1;
  logic [7:0]  fault_map1;

  strait_selftest_ctrl #(.NUM_PATTERNS(1), .ARRAY_LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
    .golden_answer(golden1), .mismatch(mismatch1),
    .pat_addr(pat_addr1), .launch(launch1), .correct_answer(correct_answer1),
    .fault_map(fault_map1), .busy(busy1), .done(done1), .fail(fail1)
  );

  int errors = 0;
  int checks = 0;

  // advance to 1 time unit after the next rising edge
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst_n = 1'b0;
    start = 0; abort = 0; mismatch = '0;
    start1 = 0; abort1 = 0; mismatch1 = 8'hFF; golden1 = 24'hABCDEF;
    tick; tick;
    checks++;
    if ({launch, busy, done, fail} !== 4'b0000 || pat_addr !== 4'd0 ||
        correct_answer !== 24'd0 || fault_map !== 8'h00) begin
      errors++;
      $display("FAIL reset_dut: launch/busy/done/fail=%b pat=%0d ca=%h fm=%h required all 0",
               {launch, busy, done, fail}, pat_addr, correct_answer, fault_map);
    end
    checks++;
    if ({launch1, busy1, done1, fail1} !== 4'b0000 || pat_addr1 !== 1'b0 ||
        correct_answer1 !== 24'd0 || fault_map1 !== 8'h00) begin
      errors++;
      $display("FAIL reset_dut1: launch/busy/done/fail=%b ca=%h fm=%h required all 0",
               {launch1, busy1, done1, fail1}, correct_answer1, fault_map1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_clean_run;
    logic       exp_launch;
    logic [3:0] exp_pa;
    start = 1'b1;
    for (int c = 1; c <= 289; c++) begin
      tick;
      start = 1'b0;
      exp_launch = (c <= 271) && (((c - 1) % 18) == 0);
      exp_pa     = (c < 289) ? 4'((c - 1) / 18) : 4'd15;
      checks++;
      if (launch !== exp_launch) begin
        errors++;
        $display("FAIL clean_launch c=%0d: got %b required %b", c, launch, exp_launch);
      end
      checks++;
      if (busy !== (c < 289) || done !== (c == 289)) begin
        errors++;
        $display("FAIL clean_busy_done c=%0d: busy=%b done=%b", c, busy, done);
      end
      checks++;
      if (pat_addr !== exp_pa) begin
        errors++;
        $display("FAIL clean_pat_addr c=%0d: got %0d required %0d", c, pat_addr, exp_pa);
      end
    end
    checks++;
    if (fail !== 1'b0 || fault_map !== 8'h00) begin
      errors++;
      $display("FAIL clean_result: fail=%b fm=%h required 0/00", fail, fault_map);
    end
  endtask

  task automatic test_faults_golden;
    int p, ph;
    start = 1'b1;
    for (int c = 1; c <= 289; c++) begin
      tick;
      start = 1'b0;
      p  = (c - 1) / 18;
      ph = (c - 1) % 18;
      // real fault in CAPTURE of pattern 3; stray flags elsewhere are ignored
      if (c < 289 && p == 3 && ph == 17)     mismatch = 8'h04;
      else if (c < 289 && p == 5 && ph == 5) mismatch = 8'h80;
      else if (c < 289 && p == 6 && ph == 0) mismatch = 8'hFF;
      else                                   mismatch = 8'h00;
      if (c == 1) begin
        checks++;
        if (fault_map !== 8'h00 || done !== 1'b0 || fail !== 1'b0) begin
          errors++;
          $display("FAIL restart_clear: fm=%h done=%b fail=%b required 00/0/0",
                   fault_map, done, fail);
        end
      end
      if ((p == 3 && ph >= 1) || (p == 4 && ph == 0)) begin
        checks++;
        if (correct_answer !== 24'h333333) begin
          errors++;
          $display("FAIL golden_p3 c=%0d: got %h required 333333", c, correct_answer);
        end
      end
      if (p == 7 && ph == 1) begin
        checks++;
        if (correct_answer !== 24'h777777) begin
          errors++;
          $display("FAIL golden_p7: got %h required 777777", correct_answer);
        end
      end
      if (c == 72 || c == 150) begin
        checks++;
        if (fault_map !== ((c == 72) ? 8'h00 : 8'h04)) begin
          errors++;
          $display("FAIL fault_sticky c=%0d: got %h", c, fault_map);
        end
      end
    end
    mismatch = 8'h00;
    checks++;
    if (done !== 1'b1 || fail !== 1'b1 || fault_map !== 8'h04) begin
      errors++;
      $display("FAIL faults_result: done=%b fail=%b fm=%h required 1/1/04",
               done, fail, fault_map);
    end
  endtask

  task automatic test_back_to_back;
    logic exp_launch;
    start = 1'b1;
    for (int c = 1; c <= 289; c++) begin
      tick;
      // extra start pulses while busy must not disturb the sequence
      start = (c == 10 || c == 18 || c == 19 || c == 288);
      exp_launch = (c <= 271) && (((c - 1) % 18) == 0);
      if (c == 1) begin
        checks++;
        if (fault_map !== 8'h00) begin
          errors++;
          $display("FAIL b2b_clear: fm=%h required 00", fault_map);
        end
      end
      checks++;
      if (launch !== exp_launch || busy !== (c < 289)) begin
        errors++;
        $display("FAIL b2b_seq c=%0d: launch=%b busy=%b required %b/%b",
                 c, launch, busy, exp_launch, (c < 289));
      end
    end
    start = 1'b0;
    checks++;
    if (done !== 1'b1 || fail !== 1'b0 || pat_addr !== 4'd15) begin
      errors++;
      $display("FAIL b2b_result: done=%b fail=%b pat=%0d required 1/0/15",
               done, fail, pat_addr);
    end
  endtask

  task automatic test_abort;
    start = 1'b1;
    for (int c = 1; c <= 132; c++) begin
      tick;
      start    = 1'b0;
      mismatch = (c == 54) ? 8'h02 : 8'h00;
      abort    = (c == 132);
    end
    tick;
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || launch !== 1'b0 ||
        fault_map !== 8'h02 || fail !== 1'b0) begin
      errors++;
      $display("FAIL abort_state: busy=%b done=%b launch=%b fm=%h fail=%b required 0/0/0/02/0",
               busy, done, launch, fault_map, fail);
    end
    tick; tick;
    checks++;
    if (busy !== 1'b0 || launch !== 1'b0 || fault_map !== 8'h02) begin
      errors++;
      $display("FAIL abort_idle: busy=%b launch=%b fm=%h", busy, launch, fault_map);
    end
    start = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      tick;
      start    = 1'b0;
      mismatch = (c == 18) ? 8'h10 : 8'h00;
      abort    = (c == 20);
      if (c == 1) begin
        checks++;
        if (launch !== 1'b1 || pat_addr !== 4'd0 || fault_map !== 8'h00 || busy !== 1'b1) begin
          errors++;
          $display("FAIL abort_restart: launch=%b pat=%0d fm=%h busy=%b required 1/0/00/1",
                   launch, pat_addr, fault_map, busy);
        end
      end
    end
    tick;
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || fault_map !== 8'h10) begin
      errors++;
      $display("FAIL abort_second: busy=%b fm=%h required 0/10", busy, fault_map);
    end
  endtask

  task automatic test_single_pattern;
    start1 = 1'b1;
    tick;
    start1 = 1'b0;
    checks++;
    if (launch1 !== 1'b1 || busy1 !== 1'b1 || fault_map1 !== 8'h00) begin
      errors++;
      $display("FAIL single_launch: launch=%b busy=%b fm=%h", launch1, busy1, fault_map1);
    end
    tick;
    checks++;
    if (launch1 !== 1'b0 || busy1 !== 1'b1 || correct_answer1 !== 24'hABCDEF ||
        fault_map1 !== 8'h00) begin
      errors++;
      $display("FAIL single_wait: launch=%b busy=%b ca=%h fm=%h",
               launch1, busy1, correct_answer1, fault_map1);
    end
    tick;
    checks++;
    if (busy1 !== 1'b1 || done1 !== 1'b0 || fault_map1 !== 8'h00) begin
      errors++;
      $display("FAIL single_capture: busy=%b done=%b fm=%h", busy1, done1, fault_map1);
    end
    tick;
    checks++;
    if (done1 !== 1'b1 || fail1 !== 1'b1 || fault_map1 !== 8'hFF || busy1 !== 1'b0) begin
      errors++;
      $display("FAIL single_done: done=%b fail=%b fm=%h busy=%b required 1/1/FF/0",
               done1, fail1, fault_map1, busy1);
    end
    // restart, then assert reset asynchronously in the middle of WAIT
    start1 = 1'b1;
    tick;
    start1 = 1'b0;
    tick;
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({launch1, busy1, done1, fail1} !== 4'b0000 || correct_answer1 !== 24'd0 ||
        fault_map1 !== 8'h00 || pat_addr1 !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_dut1: lbdf=%b ca=%h fm=%h", {launch1, busy1, done1, fail1},
               correct_answer1, fault_map1);
    end
    checks++;
    if (fault_map !== 8'h00 || correct_answer !== 24'd0 || pat_addr !== 4'd0) begin
      errors++;
      $display("FAIL async_reset_dut: fm=%h ca=%h pat=%0d required 00/0/0",
               fault_map, correct_answer, pat_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset;
    test_clean_run;
    test_faults_golden;
    test_back_to_back;
    test_abort;
    test_single_pattern;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
